gpr_writeback: RTL and testbench

Writeback stage that sits directly upstream of the 8 x 16-bit general-purpose register file and drives its single write port. It merges two result streams, single-cycle ALU results and variable-latency load results, into one registered write per cycle. ALU results always have priority. Load results are held in a 4-entry in-order FIFO until a free write slot appears. A pending-destination mask lets issue logic stall on hazards against queued loads.

---
 rtl/gpr_writeback_if.sv | 30 +++
 rtl/gpr_writeback.sv | 110 +++++++++++
 tb/tb_gpr_writeback.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_writeback_if.sv
`timescale 1ns/1ps
// Writeback bus: ALU and load result inputs, register-file write port and load-queue status.
// The master side is issue/load logic; the slave side is the writeback stage.
interface gpr_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic [2:0]        lq_count;
  logic [7:0]        pend_mask;

  modport master (
    output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
    input  ld_ready, reg_write_en, reg_write_dest, reg_write_data, lq_count, pend_mask
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
    output ld_ready, reg_write_en, reg_write_dest, reg_write_data, lq_count, pend_mask
  );
endinterface

// File: rtl/gpr_writeback.sv
`timescale 1ns/1ps
// Merges ALU results (1 cycle, always win the slot) and queued loads (>=2 cycles) into one registered
// register-file write per cycle; loads are throttled only by ld_ready, which drops when the queue is full.
module gpr_writeback #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int LQ_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  gpr_writeback_if.slave wb
);
  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LQ_DEPTH);

  logic [ADDR_W-1:0] lq_dest_q [LQ_DEPTH];
  logic [ADDR_W-1:0] lq_dest_d [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_d [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  lq_count_q, lq_count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push, pop;
  logic [7:0]        pend_mask_c;
  logic [PTR_W-1:0]  offs;

  // Readiness looks only at the registered count, so a full queue refuses even while draining.
  assign wb.ld_ready       = (lq_count_q != FULL) && rst_n;
  assign wb.reg_write_en   = we_q;
  assign wb.reg_write_dest = dest_q;
  assign wb.reg_write_data = data_q;
  assign wb.lq_count       = lq_count_q;
  assign wb.pend_mask      = pend_mask_c;

  always_comb begin
    push       = wb.ld_valid && (lq_count_q != FULL);
    pop        = !wb.alu_valid && (lq_count_q != '0);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lq_count_d = lq_count_q;
    lq_dest_d  = lq_dest_q;
    lq_data_d  = lq_data_q;
    we_d       = 1'b0;
    dest_d     = dest_q;
    data_d     = data_q;

    if (push) begin
      lq_dest_d[wr_ptr_q] = wb.ld_dest;
      lq_data_d[wr_ptr_q] = wb.ld_data;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end

    if (wb.alu_valid) begin
      we_d   = 1'b1;
      dest_d = wb.alu_dest;
      data_d = wb.alu_data;
    end else if (pop) begin
      we_d     = 1'b1;
      dest_d   = lq_dest_q[rd_ptr_q];
      data_d   = lq_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   lq_count_d = lq_count_q + 1'b1;
      2'b01:   lq_count_d = lq_count_q - 1'b1;
      default: lq_count_d = lq_count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    pend_mask_c = '0;
    offs        = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(offs) < lq_count_q) begin
        pend_mask_c = pend_mask_c | (8'b1 << lq_dest_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lq_count_q <= '0;
      we_q       <= 1'b0;
      dest_q     <= '0;
      data_q     <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_dest_q[i] <= '0;
        lq_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lq_count_q <= lq_count_d;
      we_q       <= we_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      lq_dest_q  <= lq_dest_d;
      lq_data_q  <= lq_data_d;
    end
  end
endmodule

// File: tb/tb_gpr_writeback.sv
`timescale 1ns/1ps
// Bench for gpr_writeback: directed vector table, full-queue and reset sequences, then random
// traffic, all compared against a queue-based model of the writeback rules.
module tb_gpr_writeback;
  localparam int LQ = 4;

  logic clk;
  logic rst_n;

  gpr_writeback_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  gpr_writeback #(.DATA_W(16), .ADDR_W(3), .LQ_DEPTH(LQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  d;
    logic [15:0] x;
  } ent_t;

  typedef struct {
    logic        alu_v;
    logic [2:0]  alu_d;
    logic [15:0] alu_x;
    logic        ld_v;
    logic [2:0]  ld_d;
    logic [15:0] ld_x;
    logic        e_rdy;
    logic        e_en;
    logic [2:0]  e_dest;
    logic [15:0] e_data;
    logic [2:0]  e_cnt;
    logic [7:0]  e_mask;
  } vec_t;

  ent_t        mq[$];
  logic        m_en;
  logic [2:0]  m_dest;
  logic [15:0] m_data;
  logic        rdy_seen;
  int          n_chk = 0;
  int          n_err = 0;
  vec_t        tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_mask();
    logic [7:0] m;
    m = 8'h00;
    foreach (mq[i]) m = m | (8'b1 << mq[i].d);
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_en   = 1'b0;
    m_dest = 3'd0;
    m_data = 16'h0000;
  endtask

  // One cycle: drive at negedge, update the model at posedge, compare at the next negedge.
  task automatic step(input logic av, input logic [2:0] ad, input logic [15:0] ax,
                      input logic lv, input logic [2:0] ldd, input logic [15:0] lx);
    logic acc;
    ent_t e;
    bus.alu_valid = av;
    bus.alu_dest  = ad;
    bus.alu_data  = ax;
    bus.ld_valid  = lv;
    bus.ld_dest   = ldd;
    bus.ld_data   = lx;
    #1;
    rdy_seen = bus.ld_ready;
    chk("ld_ready", 32'(bus.ld_ready), 32'(mq.size() != LQ));
    acc = lv && (mq.size() != LQ);
    @(posedge clk);
    if (av) begin
      m_en = 1'b1; m_dest = ad; m_data = ax;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_en = 1'b1; m_dest = e.d; m_data = e.x;
    end else begin
      m_en = 1'b0;
    end
    if (acc) mq.push_back({ldd, lx});
    @(negedge clk);
    chk("wr_en", 32'(bus.reg_write_en), 32'(m_en));
    chk("wr_dest", 32'(bus.reg_write_dest), 32'(m_dest));
    chk("wr_data", 32'(bus.reg_write_data), 32'(m_data));
    chk("lq_count", 32'(bus.lq_count), 32'(mq.size()));
    chk("pend_mask", 32'(bus.pend_mask), 32'(model_mask()));
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
  endtask

  function automatic vec_t mk(input logic av, input logic [2:0] ad, input logic [15:0] ax,
                              input logic lv, input logic [2:0] ldd, input logic [15:0] lx,
                              input logic er, input logic ee, input logic [2:0] ed,
                              input logic [15:0] ex, input logic [2:0] ec, input logic [7:0] em);
    vec_t v;
    v.alu_v = av; v.alu_d = ad; v.alu_x = ax;
    v.ld_v  = lv; v.ld_d  = ldd; v.ld_x = lx;
    v.e_rdy = er; v.e_en = ee; v.e_dest = ed; v.e_data = ex; v.e_cnt = ec; v.e_mask = em;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors: expectations are the outputs visible after each cycle's edge.
    tbl[0]  = mk(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd0, 8'h00);
    tbl[1]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd3, 16'hBEEF, 3'd0, 8'h00);
    tbl[2]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h1234, 1'b1, 1'b0, 3'd3, 16'hBEEF, 3'd1, 8'h20);
    tbl[3]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd5, 16'h1234, 3'd0, 8'h00);
    tbl[4]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd5, 16'h1234, 3'd0, 8'h00);
    tbl[5]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h2222, 1'b1, 1'b0, 3'd5, 16'h1234, 3'd1, 8'h04);
    tbl[6]  = mk(1'b1, 3'd1, 16'h0111, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0111, 3'd1, 8'h04);
    tbl[7]  = mk(1'b1, 3'd4, 16'h0444, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd4, 16'h0444, 3'd1, 8'h04);
    tbl[8]  = mk(1'b1, 3'd6, 16'h0666, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd6, 16'h0666, 3'd1, 8'h04);
    tbl[9]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd2, 16'h2222, 3'd0, 8'h00);
    tbl[10] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h2222, 3'd0, 8'h00);
    tbl[11] = mk(1'b1, 3'd7, 16'h7777, 1'b1, 3'd0, 16'hAAAA, 1'b1, 1'b1, 3'd7, 16'h7777, 3'd1, 8'h01);
    tbl[12] = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'hBBBB, 1'b1, 1'b1, 3'd0, 16'hAAAA, 3'd1, 8'h02);
    tbl[13] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'hBBBB, 3'd0, 8'h00);
    tbl[14] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd1, 16'hBBBB, 3'd0, 8'h00);

    // Reset held with both inputs active: nothing may enter or leave.
    rst_n = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd6; bus.alu_data = 16'hDEAD;
    bus.ld_valid  = 1'b1; bus.ld_dest  = 3'd2; bus.ld_data  = 16'hCAFE;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(bus.reg_write_en), 32'(1'b0));
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'(1'b0));
    chk("rst_lq_count", 32'(bus.lq_count), 32'(3'd0));
    chk("rst_pend_mask", 32'(bus.pend_mask), 32'(8'h00));
    chk("rst_wr_data", 32'(bus.reg_write_data), 32'(16'h0000));
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_ld_ready", 32'(bus.ld_ready), 32'(1'b1));
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].alu_v, tbl[i].alu_d, tbl[i].alu_x, tbl[i].ld_v, tbl[i].ld_d, tbl[i].ld_x);
      chk($sformatf("tbl%0d_rdy", i), 32'(rdy_seen), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_en", i), 32'(bus.reg_write_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_dest", i), 32'(bus.reg_write_dest), 32'(tbl[i].e_dest));
      chk($sformatf("tbl%0d_data", i), 32'(bus.reg_write_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.lq_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_mask", i), 32'(bus.pend_mask), 32'(tbl[i].e_mask));
    end

    // Full queue under a continuous ALU stream, then drain.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3'd7, 16'(16'h7000 + k), 1'b1, 3'(k), 16'(16'h0100 + k));
    end
    chk("full_rdy_5th", 32'(rdy_seen), 32'(1'b0));
    chk("full_cnt", 32'(bus.lq_count), 32'(3'd4));
    chk("full_ld_ready", 32'(bus.ld_ready), 32'(1'b0));
    chk("full_mask", 32'(bus.pend_mask), 32'(8'h0F));
    step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0104);
    chk("drain0_dest", 32'(bus.reg_write_dest), 32'(3'd0));
    chk("drain0_rdy", 32'(rdy_seen), 32'(1'b0));
    step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0104);
    chk("drain1_dest", 32'(bus.reg_write_dest), 32'(3'd1));
    chk("drain1_rdy", 32'(rdy_seen), 32'(1'b1));
    for (int k = 2; k < 5; k++) begin
      idle();
      chk($sformatf("drain%0d_en", k), 32'(bus.reg_write_en), 32'(1'b1));
      chk($sformatf("drain%0d_dest", k), 32'(bus.reg_write_dest), 32'(k));
      chk($sformatf("drain%0d_data", k), 32'(bus.reg_write_data), 32'(16'h0100 + k));
    end
    idle();
    chk("drain_done_en", 32'(bus.reg_write_en), 32'(1'b0));

    // Mid-operation asynchronous reset with three queued loads and a write in flight.
    step(1'b1, 3'd7, 16'h1111, 1'b1, 3'd1, 16'h0A01);
    step(1'b1, 3'd6, 16'h2222, 1'b1, 3'd3, 16'h0A03);
    step(1'b1, 3'd5, 16'h3333, 1'b1, 3'd6, 16'h0A06);
    chk("pre_rst_cnt", 32'(bus.lq_count), 32'(3'd3));
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(bus.lq_count), 32'(3'd0));
    chk("arst_en", 32'(bus.reg_write_en), 32'(1'b0));
    chk("arst_mask", 32'(bus.pend_mask), 32'(8'h00));
    chk("arst_rdy", 32'(bus.ld_ready), 32'(1'b0));
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    repeat (4) idle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic av, lv;
      av = ($urandom_range(0, 9) < 4);
      lv = ($urandom_range(0, 9) < 6);
      step(av, 3'($urandom_range(0, 7)), 16'($urandom), lv, 3'($urandom_range(0, 7)), 16'($urandom));
    end
    repeat (6) idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
